duty_pct_display: RTL
=====================

Name: duty_pct_display

Overview:
- Downstream display stage for the PWM counter. Consumes the duty-cycle percentage output (0..100) and shows it on the board's 4-digit common-anode seven-segment display.
- Converts binary to BCD with a sequential shift-add-3 (double dabble) FSM.
- Time-multiplexes the digits with a refresh counter.
- Display registers update atomically, so a half-converted value is never shown.

Parameters:
- IN_W, 27: width of the duty_pct input.
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range >= 2.
- MAX_PCT, 100: saturation ceiling applied to the input.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- duty_pct  in  IN_W  binary duty percentage from the PWM counter.
- an  out  4  digit anodes, active low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low; held 1 (off).
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Single clock domain, asynchronous active-low reset.
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, busy=0, state=IDLE, last_val=0, hundreds/tens/ones display registers=0, scan counter=0, digit index=0.
- Input clamp: v = (duty_pct > MAX_PCT) ? MAX_PCT : duty_pct[6:0]. The comparison uses the full IN_W width.
- FSM states:
  - IDLE: if v != last_val, latch v into the shift register, clear the BCD scratch, set last_val=v, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: 7 iterations, one per cycle. Each iteration adds 3 to every scratch nibble that is >= 5, then shifts left by 1. An iteration counter runs 0..6; on iteration 6 go to COMMIT.
  - COMMIT: copy scratch hundreds/tens/ones into the display registers, then go to IDLE.
- busy=1 in SHIFT and COMMIT, 0 in IDLE.
- Latency: change sampled in IDLE at cycle N; display registers hold the new value at the end of cycle N+8 (1 latch + 7 shift + 1 commit cycles).
- Input changes during SHIFT/COMMIT are ignored. The first IDLE cycle after COMMIT re-compares, so the final value is always displayed; there is no lost update.
- Equal values never restart the conversion.
- Scan:
  - The counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, digit index advances 0→1→2→3→0.
  - an and seg are registered from the index and display registers, valid one cycle after each index change.
  - Digit map: idx0 = ones, idx1 = tens, idx2 = hundreds, idx3 = always blank (seg=7'h7F, its anode is still driven for uniform duty).
- Segment codes:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - blank=7'h7F
- Saturation: any duty_pct > 100, including upper bits of the 27-bit input, displays "100".
- Reset mid-conversion: the FSM aborts to IDLE, the display shows 0, and the next cycle after release re-evaluates the input against last_val=0.

Optional Feature:
- Macro: DUTY_LZ_BLANK_EN.
- Defined: leading zeros are blanked.
  - hundreds == 0 → hundreds digit blank.
  - hundreds == 0 and tens == 0 → tens digit blank.
  - Ones is always shown. Example: 7 displays as "   7".
- Undefined: all three digits are shown. Example: 7 displays as " 007".

Decomposition:
- Package seg7_pkg holds:
  - the state enum (IDLE, SHIFT, COMMIT);
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - a bcd_to_seg function;
  - DIGITS=4.
- Sub-module bin2bcd_seq holds the IDLE/SHIFT/COMMIT FSM plus scratch registers, with ports start, bin[6:0], busy, done, hundreds, tens, ones.
- The top level owns the clamp, change detect, display registers and scan mux.

Test Plan:
- Reset with duty_pct=50, then release → busy high for 8 cycles; the display registers read 0/5/0 at cycle 9. With REFRESH_DIV=4, the scan shows an=1110 seg=7'h40, then an=1101 seg=7'h12.
- duty_pct 100 → 7 → 0 in sequence, each held 20 cycles → hundreds/tens/ones read 1/0/0, then 0/0/7, then 0/0/0. With DUTY_LZ_BLANK_EN, the idx1/idx2 segments read 7'h7F for 7.
- duty_pct=27'h4000064 (upper bit set) → clamps to 100 and displays 1/0/0.
- duty_pct changes 30→80 on the 3rd SHIFT cycle → display shows 30 after the first commit, busy reasserts the next cycle, and the display shows 80 nine cycles later.
- Constant duty_pct held for 1000 cycles after the first conversion → busy stays 0 and no re-conversion occurs.
- Assert rst_n low during SHIFT → an=1111 and seg=7F immediately (async), FSM returns to IDLE, and the conversion restarts after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and seven-segment constants for the duty_pct_display slice.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to 3-digit BCD converter (shift-add-3).
// One latch cycle, seven shift cycles, then one COMMIT cycle flagged by done.
module bin2bcd_seq
   import seg7_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] bin,
   output logic       busy,
   output logic       done,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   state_t     state_q, state_d;
   logic [2:0] iter_q, iter_d;
   logic [6:0] sh_q, sh_d;
   logic [3:0] h_q, h_d, t_q, t_d, o_q, o_d;
   logic [3:0] h_a_s, t_a_s, o_a_s;

   // State and scratch registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         iter_q  <= 3'd0;
         sh_q    <= 7'd0;
         h_q     <= 4'd0;
         t_q     <= 4'd0;
         o_q     <= 4'd0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         sh_q    <= sh_d;
         h_q     <= h_d;
         t_q     <= t_d;
         o_q     <= o_d;
      end
   end

   // Next-state logic and one add-3-then-shift iteration per SHIFT cycle
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      sh_d    = sh_q;
      h_d     = h_q;
      t_d     = t_q;
      o_d     = o_q;
      h_a_s   = (h_q >= 4'd5) ? h_q + 4'd3 : h_q;
      t_a_s   = (t_q >= 4'd5) ? t_q + 4'd3 : t_q;
      o_a_s   = (o_q >= 4'd5) ? o_q + 4'd3 : o_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = bin;
               h_d     = 4'd0;
               t_d     = 4'd0;
               o_d     = 4'd0;
               iter_d  = 3'd0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            // Hundreds never exceeds 1 for a 7-bit input, so its carry-out is dropped
            {h_d, t_d, o_d, sh_d} = {h_a_s[2:0], t_a_s, o_a_s, sh_q, 1'b0};
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd6) begin
               state_d = COMMIT;
            end else begin
               state_d = SHIFT;
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == COMMIT);
   assign hundreds = h_q;
   assign tens     = t_q;
   assign ones     = o_q;

endmodule

// File: rtl/duty_pct_display.sv
// Duty-cycle percentage to 4-digit multiplexed seven-segment display.
// Define DUTY_LZ_BLANK_EN to blank leading zeros on the tens/hundreds digits.
module duty_pct_display
   import seg7_pkg::*;
#(
   parameter int IN_W        = 27,
   parameter int REFRESH_DIV = 100000,
   parameter int MAX_PCT     = 100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IN_W-1:0] duty_pct,
   output logic [3:0]      an,
   output logic [6:0]      seg,
   output logic            dp,
   output logic            busy
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [6:0]       v_s;
   logic             start_s, done_s;
   logic [3:0]       h_s, t_s, o_s;
   logic [6:0]       last_val_q, last_val_d;
   logic [3:0]       hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;

   // Saturating clamp over the full input width, then change detect while idle
   always_comb begin
      if (duty_pct > IN_W'(MAX_PCT)) begin
         v_s = 7'(MAX_PCT);
      end else begin
         v_s = duty_pct[6:0];
      end
      start_s = !busy && (v_s != last_val_q);
   end

   bin2bcd_seq u_bcd (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_s),
      .bin      (v_s),
      .busy     (busy),
      .done     (done_s),
      .hundreds (h_s),
      .tens     (t_s),
      .ones     (o_s)
   );

   // Display registers load all three digits together on commit
   always_comb begin
      last_val_d = start_s ? v_s : last_val_q;
      hund_d     = done_s ? h_s : hund_q;
      tens_d     = done_s ? t_s : tens_q;
      ones_d     = done_s ? o_s : ones_q;
      cnt_d      = cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_d = CNT_W'(0);
         idx_d = idx_q + 2'd1;
      end else begin
         idx_d = idx_q;
      end
   end

   // Digit mux; the fourth digit is always blank but keeps its scan slot
   always_comb begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = SEG_BLANK;
      case (idx_q)
         2'd0: seg_d = bcd_to_seg(ones_q);
`ifdef DUTY_LZ_BLANK_EN
         2'd1: begin
            if ((hund_q == 4'd0) && (tens_q == 4'd0)) begin
               seg_d = SEG_BLANK;
            end else begin
               seg_d = bcd_to_seg(tens_q);
            end
         end
         2'd2: begin
            if (hund_q == 4'd0) begin
               seg_d = SEG_BLANK;
            end else begin
               seg_d = bcd_to_seg(hund_q);
            end
         end
`else
         2'd1: seg_d = bcd_to_seg(tens_q);
         2'd2: seg_d = bcd_to_seg(hund_q);
`endif
         default: seg_d = SEG_BLANK;
      endcase
   end

   // Display, scan and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_val_q <= 7'd0;
         hund_q     <= 4'd0;
         tens_q     <= 4'd0;
         ones_q     <= 4'd0;
         cnt_q      <= CNT_W'(0);
         idx_q      <= 2'd0;
         an_q       <= 4'b1111;
         seg_q      <= SEG_BLANK;
      end else begin
         last_val_q <= last_val_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = 1'b1;

endmodule
